pipe_stage_reg: RTL
===================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32: width of each of the three data words (data1, data2, funct/sign-extended immediate).
REQ-002 Parameter REG_W, default 5: width of the rd and shamt fields.
REQ-003 Parameter PC_W, default 8: width of the next-instruction (adder) field.
REQ-004 Parameter CNT_W, default 8: width of the stall-cycle counter.
REQ-005 clk_PSR  input  1  single clock, all state updates on its rising edge.
REQ-006 rst_n_PSR  input  1  reset, asynchronous assert, active-low.
REQ-007 in_valid_PSR  input  1  upstream stage presents a valid instruction bundle.
REQ-008 in_ready_PSR  output  1  stage can accept a bundle this cycle.
REQ-009 dIn1_PSR, dIn2_PSR, dIn3_PSR  input  DATA_W each  data1, data2, funct words.
REQ-010 dIn4_PSR, dIn5_PSR  input  REG_W each  rd, shamt.
REQ-011 dIn6_PSR  input  PC_W  next-instruction address.
REQ-012 flush_PSR  input  1  synchronous squash of all held bundles.
REQ-013 out_valid_PSR  output  1  output bundle valid.
REQ-014 out_ready_PSR  input  1  downstream stage consumes the bundle this cycle.
REQ-015 data1_PSR, data2_PSR, funct_PSR  output  DATA_W each; rd_PSR, shamt_PSR  output  REG_W each; nextIns_PSR  output  PC_W: registered bundle fields.
REQ-016 occ_PSR  output  2  number of held bundles (0..2).
REQ-017 stall_cnt_PSR  output  CNT_W  saturating count of back-pressure cycles.

Function
REQ-018 Two storage slots: main (M, drives outputs) and skid (S); bundles leave in arrival order.
REQ-019 Accept = in_valid_PSR && in_ready_PSR; Drain = out_valid_PSR && out_ready_PSR.
REQ-020 in_ready_PSR = NOT S.valid, driven from a register only (no combinational path from out_ready_PSR).
REQ-021 out_valid_PSR = M.valid; outputs show M contents directly from flops.
REQ-022 occ 0: Accept -> M loaded, occ 1; latency accept-to-out_valid exactly 1 cycle.
REQ-023 occ 1: Accept&Drain -> M reloaded, occ 1; Accept only -> S loaded, occ 2; Drain only -> occ 0.
REQ-024 occ 2: in_ready low; Drain -> M<=S, S emptied, occ 1; no Drain -> hold.
REQ-025 Holding with out_valid high: all output fields stable until Drain.
REQ-026 flush_PSR high -> next cycle M.valid=S.valid=0, occ 0; bundle offered in the same cycle discarded; flush overrides Accept and Drain.
REQ-027 Data fields of invalid slots are don't-care but SHALL NOT change out_valid/occ.
REQ-028 stall_cnt_PSR increments each cycle out_valid_PSR && !out_ready_PSR, saturates at 2^CNT_W-1, cleared by flush_PSR.
REQ-029 Full throughput: continuous in_valid and out_ready sustain one bundle per cycle.

Reset
REQ-030 rst_n_PSR low asynchronously clears M.valid, S.valid, occ_PSR, stall_cnt_PSR and all output data fields to 0.
REQ-031 During and first cycle after reset, in_ready_PSR=1 and out_valid_PSR=0; reset mid-transfer discards all held bundles.

Structure
REQ-032 Package pipe_pkg holds default DATA_W/REG_W/PC_W/CNT_W and the bundle width constant BUNDLE_W = 3*DATA_W+2*REG_W+PC_W.
REQ-033 One sub-module pipe_slot (valid bit + BUNDLE_W payload with load/clear), instantiated twice for M and S.

Verification
REQ-034 Reset, then one bundle dIn1=0x11111111, rd=3, out_ready=1 -> out_valid next cycle, data1_PSR=0x11111111, rd_PSR=3, occ 1 then 0.
REQ-035 out_ready=0, feed bundles A(nextIns=0x04), B(0x08), C(0x0C) -> occ 2, in_ready 0 from third cycle, C held upstream; release -> A, B, C in order, one per cycle.
REQ-036 occ 2 and flush_PSR=1 with in_valid=1 -> next cycle occ 0, out_valid 0, stall_cnt 0, offered bundle never appears.
REQ-037 CNT_W=3, out_ready=0 for 10 cycles with out_valid=1 -> stall_cnt_PSR reaches 7 and holds.
REQ-038 Random valid/ready for 10000 cycles vs. scoreboard FIFO -> no loss, duplication or reorder; in_ready never depends combinationally on out_ready.
REQ-039 rst_n_PSR asserted mid-cycle at occ 2 -> outputs and occ zero immediately, without waiting for clk_PSR.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths for the two-slot pipeline stage register.
package pipe_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_W  = 5;
    localparam int DEF_PC_W   = 8;
    localparam int DEF_CNT_W  = 8;

    function automatic int bundle_width(input int data_w, input int reg_w, input int pc_w);
        return 3 * data_w + 2 * reg_w + pc_w;
    endfunction

    localparam int BUNDLE_W = bundle_width(DEF_DATA_W, DEF_REG_W, DEF_PC_W);
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one storage slot (valid bit plus payload) with load and clear.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int W = BUNDLE_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] data
);
    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    // clear wins; payload of a cleared slot is left as-is since it is don't-care
    always_comb begin
        valid_d = clear ? 1'b0 : load ? 1'b1 : valid_q;
        data_d  = (load && !clear) ? d : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: skid-buffered pipeline register with registered ready, flush and stall counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W,
    parameter int PC_W   = DEF_PC_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk_PSR,
    input  logic              rst_n_PSR,
    input  logic              in_valid_PSR,
    output logic              in_ready_PSR,
    input  logic [DATA_W-1:0] dIn1_PSR,
    input  logic [DATA_W-1:0] dIn2_PSR,
    input  logic [DATA_W-1:0] dIn3_PSR,
    input  logic [REG_W-1:0]  dIn4_PSR,
    input  logic [REG_W-1:0]  dIn5_PSR,
    input  logic [PC_W-1:0]   dIn6_PSR,
    input  logic              flush_PSR,
    output logic              out_valid_PSR,
    input  logic              out_ready_PSR,
    output logic [DATA_W-1:0] data1_PSR,
    output logic [DATA_W-1:0] data2_PSR,
    output logic [DATA_W-1:0] funct_PSR,
    output logic [REG_W-1:0]  rd_PSR,
    output logic [REG_W-1:0]  shamt_PSR,
    output logic [PC_W-1:0]   nextIns_PSR,
    output logic [1:0]        occ_PSR,
    output logic [CNT_W-1:0]  stall_cnt_PSR
);
    localparam int BW = bundle_width(DATA_W, REG_W, PC_W);

    logic [BW-1:0]    in_bundle, m_din, m_data, s_data;
    logic             m_valid, s_valid, accept, drain;
    logic             m_load, m_clear, s_load, s_clear;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    assign in_bundle = {dIn1_PSR, dIn2_PSR, dIn3_PSR, dIn4_PSR, dIn5_PSR, dIn6_PSR};

    // S can only be occupied while M is, so a drain with S full always refills M from S
    always_comb begin
        accept      = in_valid_PSR && !s_valid;
        drain       = m_valid && out_ready_PSR;
        m_load      = !flush_PSR && (s_valid ? drain : accept && (!m_valid || drain));
        m_din       = s_valid ? s_data : in_bundle;
        m_clear     = flush_PSR || (drain && !m_load);
        s_load      = !flush_PSR && accept && m_valid && !drain;
        s_clear     = flush_PSR || (s_valid && drain);
        stall_cnt_d = flush_PSR ? '0 :
                      (m_valid && !out_ready_PSR && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 :
                      stall_cnt_q;
    end

    always_ff @(posedge clk_PSR or negedge rst_n_PSR) begin
        if (!rst_n_PSR)
            stall_cnt_q <= '0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    pipe_slot #(.W(BW)) u_main (
        .clk   (clk_PSR),
        .rst_n (rst_n_PSR),
        .load  (m_load),
        .clear (m_clear),
        .d     (m_din),
        .valid (m_valid),
        .data  (m_data)
    );

    pipe_slot #(.W(BW)) u_skid (
        .clk   (clk_PSR),
        .rst_n (rst_n_PSR),
        .load  (s_load),
        .clear (s_clear),
        .d     (in_bundle),
        .valid (s_valid),
        .data  (s_data)
    );

    assign {data1_PSR, data2_PSR, funct_PSR, rd_PSR, shamt_PSR, nextIns_PSR} = m_data;
    assign in_ready_PSR  = !s_valid;
    assign out_valid_PSR = m_valid;
    assign occ_PSR       = {1'b0, m_valid} + {1'b0, s_valid};
    assign stall_cnt_PSR = stall_cnt_q;
endmodule
